// File: rtl/data_cache_pkg.sv
// Shared types and address-split helpers for the write-back data cache.
package data_cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int num_sets, input int words_per_line);
    return ADDR_W - BYTE_OFF_W - $clog2(num_sets) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty/data per set, combinational read, one write port.
// Writes land at the next edge; valid/dirty clear on reset, tags and data keep their contents.
module dcache_way
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS       = 4,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF_W = offset_w(WORDS_PER_LINE),
  localparam int IDX_W = index_w(NUM_SETS),
  localparam int TAG_W = tag_w(NUM_SETS, WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [31:0]      rd_word,
  input  logic             wr_word_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_word,
  input  logic             set_dirty,
  input  logic             install,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [31:0]      data_q [NUM_SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (set_dirty) dirty_d[wr_idx] = 1'b1;
    if (install) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_word_en) data_q[wr_idx][wr_off] <= wr_word;
    if (install)    tag_q[wr_idx]          <= wr_tag;
  end

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/data_cache_wb.sv
// 2-way write-back, write-allocate data cache; hits answer in the same cycle with no stall.
// Misses stall the CPU through optional writeback then refill bursts, one beat per mem_ready cycle.
module data_cache_wb
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS       = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int OFF_W    = offset_w(WORDS_PER_LINE);
  localparam int IDX_W    = index_w(NUM_SETS);
  localparam int TAG_W    = tag_w(NUM_SETS, WORDS_PER_LINE);
  localparam int LINE_LSB = BYTE_OFF_W + OFF_W;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic                victim_q, victim_d;
  logic [ADDR_W-1:0]   miss_base_q, miss_base_d;
  logic [ADDR_W-1:0]   victim_base_q, victim_base_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic [OFF_W-1:0] cpu_off, rd_off, wr_off;
  logic [IDX_W-1:0] cpu_idx, miss_idx, rd_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [TAG_W-1:0] way_tag [2];
  logic [31:0]      way_word [2];
  logic [1:0]       way_valid, way_dirty, way_hit;
  logic [1:0]       wr_word_en, set_dirty, install;
  logic [31:0]      wr_word, beat_off;
  logic             is_idle, req, is_load, hit, hit_way, last_beat, victim_sel;
  logic             unused_bits;

  assign cpu_off     = cpu_addr[BYTE_OFF_W +: OFF_W];
  assign cpu_idx     = cpu_addr[LINE_LSB +: IDX_W];
  assign cpu_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
  assign miss_idx    = miss_base_q[LINE_LSB +: IDX_W];
  assign unused_bits = ^cpu_addr[BYTE_OFF_W-1:0];

  assign is_idle = (state_q == IDLE);
  assign req     = cpu_read_en | cpu_write_en;
  assign is_load = cpu_read_en & ~cpu_write_en;

  // Outside IDLE both ports follow the latched miss set and the burst beat.
  assign rd_idx  = is_idle ? cpu_idx : miss_idx;
  assign rd_off  = is_idle ? cpu_off : beat_q;
  assign wr_off  = rd_off;
  assign wr_word = is_idle ? cpu_wdata : mem_rdata;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .NUM_SETS      (NUM_SETS),
      .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (rd_idx),
      .rd_off    (rd_off),
      .rd_tag    (way_tag[w]),
      .rd_valid  (way_valid[w]),
      .rd_dirty  (way_dirty[w]),
      .rd_word   (way_word[w]),
      .wr_word_en(wr_word_en[w]),
      .wr_idx    (rd_idx),
      .wr_off    (wr_off),
      .wr_word   (wr_word),
      .set_dirty (set_dirty[w]),
      .install   (install[w]),
      .wr_tag    (miss_base_q[ADDR_W-1 -: TAG_W])
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == cpu_tag);
  end

  assign hit       = is_idle && (|way_hit);
  assign hit_way   = way_hit[1];
  assign cpu_stall = !is_idle || (req && !hit);
  assign cpu_rdata = (is_load && hit) ? way_word[hit_way] : 32'd0;

  assign last_beat    = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  assign beat_off     = {{(ADDR_W-OFF_W-2){1'b0}}, beat_q, 2'b00};
  assign mem_read_en  = (state_q == REFILL);
  assign mem_write_en = (state_q == WRITEBACK);
  assign mem_addr     = mem_read_en  ? (miss_base_q | beat_off) :
                        mem_write_en ? (victim_base_q | beat_off) : 32'd0;
  assign mem_wdata    = mem_write_en ? way_word[victim_q] : 32'd0;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    victim_d      = victim_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    lru_d         = lru_q;
    wr_word_en    = '0;
    set_dirty     = '0;
    install       = '0;
    victim_sel    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          lru_d[cpu_idx] = ~hit_way;
          if (cpu_write_en) begin
            wr_word_en[hit_way] = 1'b1;
            set_dirty[hit_way]  = 1'b1;
          end
        end else if (req) begin
          if (!way_valid[0])      victim_sel = 1'b0;
          else if (!way_valid[1]) victim_sel = 1'b1;
          else                    victim_sel = lru_q[cpu_idx];
          victim_d      = victim_sel;
          beat_d        = '0;
          miss_base_d   = {cpu_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
          victim_base_d = {way_tag[victim_sel], cpu_idx, {LINE_LSB{1'b0}}};
          state_d       = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_ready) begin
          wr_word_en[victim_q] = 1'b1;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            install[victim_q] = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An aborted transfer must not leave a partial line or a stray store behind.
    if (reset) begin
      wr_word_en = '0;
      set_dirty  = '0;
      install    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      victim_q      <= 1'b0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      lru_q         <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      victim_q      <= victim_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
      lru_q         <= lru_d;
    end
  end

endmodule

// File: tb/tb_data_cache_wb.sv
// Scoreboard bench for data_cache_wb: a flat-memory view plus a tag/LRU model predict loads and bursts.
module tb_data_cache_wb;
  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read_en, cpu_write_en, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_read_en, mem_write_en, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_cache_wb #(.NUM_SETS(NS), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { bit v; bit d; logic [31:0] tag; } mline_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cv  [logic [31:0]];
  mline_t      mw [NS][2];
  bit          mlru [NS];
  bit          rand_ready = 1'b0;
  int          hold_beat = -1;
  int          hold_cnt = 0;
  int          rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a;
  endfunction

  function automatic logic [31:0] cv_get(input logic [31:0] a);
    return cv.exists(a) ? cv[a] : a;
  endfunction

  // Reset forgets every line; the CPU view falls back to what actually reached memory.
  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      mlru[s] = 1'b0;
      for (int w = 0; w < 2; w++) mw[s][w] = '{v: 1'b0, d: 1'b0, tag: 32'd0};
    end
    cv = mem;
  endfunction

  function automatic bit model_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int          set;
    int          way;
    bit          hit;
    logic [31:0] tag, base, wa, vb;
    set  = int'(addr[5:4]);
    tag  = addr >> 6;
    base = addr & ~32'hF;
    wa   = addr & ~32'h3;
    way  = -1;
    for (int w = 0; w < 2; w++)
      if (mw[set][w].v && mw[set][w].tag == tag) way = w;
    hit = (way >= 0);
    if (!hit) begin
      if (!mw[set][0].v)      way = 0;
      else if (!mw[set][1].v) way = 1;
      else                    way = int'(mlru[set]);
      if (mw[set][way].v && mw[set][way].d) begin
        vb = (mw[set][way].tag << 6) | (set << 4);
        for (int i = 0; i < 4; i++)
          exp_beats.push_back('{wr: 1'b1, addr: vb + 4*i, data: cv_get(vb + 4*i)});
      end
      for (int i = 0; i < 4; i++)
        exp_beats.push_back('{wr: 1'b0, addr: base + 4*i, data: 32'd0});
      mw[set][way] = '{v: 1'b1, d: 1'b0, tag: tag};
    end
    mlru[set] = (way == 0);
    if (wr) begin
      mw[set][way].d = 1'b1;
      cv[wa] = wdata;
    end else begin
      exp_rd.push_back(cv_get(wa));
    end
    return hit;
  endfunction

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    bit hit;
    int cyc;
    hit = model_req(wr, addr, wdata);
    cyc = 0;
    @(posedge clk); #1;
    cpu_read_en = rd; cpu_write_en = wr; cpu_addr = addr; cpu_wdata = wdata;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      cyc++;
      if (cyc > 500) begin
        chk("req_timeout", 32'd1, 32'd0);
        break;
      end
    end
    if (hit) chk("hit_stall_cycles", cyc, 0);
    @(posedge clk); #1;
    cpu_read_en = 0; cpu_write_en = 0; cpu_addr = 0; cpu_wdata = 0;
    chk("beats_drained", exp_beats.size(), 0);
    chk("loads_drained", exp_rd.size(), 0);
  endtask

  // CPU-side monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_read_en && !cpu_write_en && !cpu_stall) begin
        if (exp_rd.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
        else chk("load_rdata", cpu_rdata, exp_rd.pop_front());
      end else if (cpu_write_en && !cpu_stall) begin
        chk("store_rdata", cpu_rdata, 32'd0);
      end else if (!cpu_read_en && !cpu_write_en) begin
        chk("idle_stall", cpu_stall, 32'd0);
        chk("idle_rdata", cpu_rdata, 32'd0);
      end
    end
  end

  // Memory model and bus monitor
  logic [31:0] prev_addr, prev_wdata;
  bit          prev_act, prev_ready;
  always @(negedge clk) begin
    bit    act, rdy;
    beat_t b;
    if (reset) begin
      mem_ready = 1'b0; mem_rdata = 32'd0;
      prev_act = 1'b0; prev_ready = 1'b0; rd_cnt = 0;
    end else begin
      act = mem_read_en || mem_write_en;
      chk("mem_en_exclusive", 32'(mem_read_en && mem_write_en), 32'd0);
      if (!act) begin
        rd_cnt = 0;
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
      end else begin
        chk("busy_stall", cpu_stall, 32'd1);
      end
      if (act && prev_act && !prev_ready) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_wdata", mem_wdata, prev_wdata);
      end
      rdy = 1'b0;
      if (act) begin
        if (mem_read_en && rd_cnt == hold_beat && hold_cnt > 0) hold_cnt--;
        else rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (rdy) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", mem_addr, 32'hFFFF_FFFF);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_dir", 32'(mem_write_en), 32'(b.wr));
          chk("beat_addr", mem_addr, b.addr);
          if (b.wr) chk("wb_data", mem_wdata, b.data);
        end
        if (mem_write_en) mem[mem_addr] = mem_wdata;
        else rd_cnt++;
      end
      mem_rdata  = mem_read_en ? mem_get(mem_addr) : 32'd0;
      mem_ready  = rdy;
      prev_act   = act;
      prev_ready = rdy;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    int op;
    cpu_read_en = 0; cpu_write_en = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", cpu_stall, 32'd0);
    chk("rst_mem_rd", mem_read_en, 32'd0);
    chk("rst_mem_wr", mem_write_en, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_req(1, 0, 32'h40, 0);
    do_req(1, 0, 32'h48, 0);
    do_req(0, 1, 32'h44, 32'hCAFEF00D);
    do_req(1, 0, 32'h44, 0);
    do_req(1, 0, 32'h80, 0);
    do_req(1, 0, 32'h80, 0);
    do_req(1, 0, 32'hC0, 0);

    hold_beat = 2; hold_cnt = 3;
    do_req(1, 0, 32'h100, 0);
    chk("hold_consumed", hold_cnt, 0);
    hold_beat = -1;
    do_req(1, 0, 32'h108, 0);
    do_req(1, 1, 32'h200, 32'h12345678);
    do_req(1, 0, 32'h200, 0);

    // Abort a refill at beat 2 with reset, then refetch the whole line.
    hold_beat = 2; hold_cnt = 1000000;
    void'(model_req(1'b0, 32'h140, 32'd0));
    @(posedge clk); #1;
    cpu_read_en = 1; cpu_addr = 32'h140;
    cyc = 0;
    while (!(mem_read_en && rd_cnt == 2) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached_beat2", 32'(cyc < 200), 32'd1);
    reset = 1'b1; cpu_read_en = 0; cpu_addr = 0;
    exp_beats.delete(); exp_rd.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_rd", mem_read_en, 32'd0);
    chk("abort_mem_wr", mem_write_en, 32'd0);
    chk("abort_stall", cpu_stall, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; hold_cnt = 0; hold_beat = -1;
    model_reset();
    do_req(1, 0, 32'h140, 0);
    do_req(1, 0, 32'h14C, 0);

    rand_ready = 1'b1;
    repeat (400) begin
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, 32'($urandom_range(0, 127)) * 4, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
